// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared pipeline types: exception causes, store sizes, commit states
package pipeline_pkg;

    localparam logic [5:0] EXC_STORE_MISALIGNED   = 6'd6;
    localparam logic [5:0] EXC_STORE_ACCESS_FAULT = 6'd7;

    // Encoding 2'd3 is deliberately absent: it is the illegal size.
    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } store_size_e;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        STORE_WAIT = 2'd1,
        FLUSH      = 2'd2
    } commit_state_e;

endpackage

// File: rtl/store_commit_if.sv
// rtl/store_commit_if.sv - execute-bundle handshake and data-memory store bus
// master: execute stage / memory side (drives bundle, dmem_ack)
// slave:  store_commit (drives ex_stall and the dmem request)
interface store_commit_if;
    logic        ex_valid;
    logic        ex_stall;
    logic [4:0]  ex_rd;
    logic [31:0] ex_rd_val;
    logic [31:0] ex_inst_pc;
    logic [31:0] ex_jump_pc;
    logic        ex_jump;
    logic [5:0]  ex_exception_num;
    logic [31:0] ex_exception_val;
    logic        ex_exception_valid;
    logic [31:0] ex_store_addr;
    logic [31:0] ex_store_val;
    logic [1:0]  ex_store_size;
    logic        ex_store_valid;
    logic        dmem_req;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_ack;

    modport master (
        output ex_valid, ex_rd, ex_rd_val, ex_inst_pc, ex_jump_pc, ex_jump,
               ex_exception_num, ex_exception_val, ex_exception_valid,
               ex_store_addr, ex_store_val, ex_store_size, ex_store_valid, dmem_ack,
        input  ex_stall, dmem_req, dmem_addr, dmem_wdata, dmem_wstrb
    );

    modport slave (
        input  ex_valid, ex_rd, ex_rd_val, ex_inst_pc, ex_jump_pc, ex_jump,
               ex_exception_num, ex_exception_val, ex_exception_valid,
               ex_store_addr, ex_store_val, ex_store_size, ex_store_valid, dmem_ack,
        output ex_stall, dmem_req, dmem_addr, dmem_wdata, dmem_wstrb
    );
endinterface

// File: rtl/store_align.sv
// rtl/store_align.sv - combinational store lane alignment and misalignment detection
// in:  addr (byte address), size (store size code), val (right-aligned data)
// out: word_addr, wstrb (byte enables), wdata (lane-replicated), misaligned
module store_align
    import pipeline_pkg::*;
(
    input  logic [31:0] addr,
    input  logic [1:0]  size,
    input  logic [31:0] val,
    output logic [31:0] word_addr,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic        misaligned
);

    assign word_addr = {addr[31:2], 2'b00};

    always_comb begin
        wstrb      = 4'h0;
        wdata      = val;
        misaligned = 1'b1;
        case (size)
            SIZE_BYTE: begin
                wstrb      = 4'b0001 << addr[1:0];
                wdata      = {4{val[7:0]}};
                misaligned = 1'b0;
            end
            SIZE_HALF: begin
                wstrb      = 4'b0011 << addr[1:0];
                wdata      = {2{val[15:0]}};
                misaligned = addr[0];
            end
            SIZE_WORD: begin
                wstrb      = 4'hF;
                wdata      = val;
                misaligned = (addr[1:0] != 2'b00);
            end
            default: begin
                misaligned = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/store_commit.sv
// rtl/store_commit.sv - final pipeline stage: writeback, stores, redirects, traps
// ports: clk, reset (sync, active-high); bus (store_commit_if.slave: execute bundle,
//        ex_stall, dmem store bus); wb_en/wb_rd/wb_val; commit_rd; redirect_valid/pc;
//        flush_out; trap_valid/num/val/pc; retire; instret (only with STORE_COMMIT_INSTRET_EN)
// macro: STORE_COMMIT_INSTRET_EN adds a 64-bit retired-instruction counter output
module store_commit
    import pipeline_pkg::*;
#(
    parameter int DMEM_TIMEOUT  = 255,
    parameter bit FLUSH_ON_JUMP = 1'b1
) (
    input  logic           clk,
    input  logic           reset,
    store_commit_if.slave  bus,
    output logic           wb_en,
    output logic [4:0]     wb_rd,
    output logic [31:0]    wb_val,
    output logic [4:0]     commit_rd,
    output logic           redirect_valid,
    output logic [31:0]    redirect_pc,
    output logic           flush_out,
    output logic           trap_valid,
    output logic [5:0]     trap_num,
    output logic [31:0]    trap_val,
    output logic [31:0]    trap_pc,
    output logic           retire
`ifdef STORE_COMMIT_INSTRET_EN
    ,
    output logic [63:0]    instret
`endif
);

    localparam int CW          = (DMEM_TIMEOUT > 1) ? $clog2(DMEM_TIMEOUT) : 1;
    localparam int TO_LAST_INT = (DMEM_TIMEOUT > 0) ? DMEM_TIMEOUT - 1 : 0;
    localparam logic [CW-1:0] TO_LAST = TO_LAST_INT[CW-1:0];

    commit_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   st_addr_q, st_addr_d;
    logic [31:0]   st_pc_q, st_pc_d;

    logic          wb_en_d, redirect_valid_d, flush_d, trap_valid_d, retire_d;
    logic [4:0]    wb_rd_d, commit_rd_d;
    logic [31:0]   wb_val_d, redirect_pc_d, trap_val_d, trap_pc_d;
    logic [5:0]    trap_num_d;
    logic          req_q, req_d;
    logic [31:0]   addr_q, addr_d, wdata_q, wdata_d;
    logic [3:0]    wstrb_q, wstrb_d;

    logic [31:0]   al_addr, al_wdata;
    logic [3:0]    al_wstrb;
    logic          al_misaligned;
    logic          accept;

    store_align u_align (
        .addr       (bus.ex_store_addr),
        .size       (bus.ex_store_size),
        .val        (bus.ex_store_val),
        .word_addr  (al_addr),
        .wstrb      (al_wstrb),
        .wdata      (al_wdata),
        .misaligned (al_misaligned)
    );

    assign bus.ex_stall   = (state_q != IDLE);
    assign bus.dmem_req   = req_q;
    assign bus.dmem_addr  = addr_q;
    assign bus.dmem_wdata = wdata_q;
    assign bus.dmem_wstrb = wstrb_q;

    assign accept = bus.ex_valid && (state_q == IDLE);

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        st_addr_d        = st_addr_q;
        st_pc_d          = st_pc_q;
        wb_en_d          = 1'b0;
        redirect_valid_d = 1'b0;
        flush_d          = 1'b0;
        trap_valid_d     = 1'b0;
        retire_d         = 1'b0;
        wb_rd_d          = wb_rd;
        wb_val_d         = wb_val;
        commit_rd_d      = commit_rd;
        redirect_pc_d    = redirect_pc;
        trap_num_d       = trap_num;
        trap_val_d       = trap_val;
        trap_pc_d        = trap_pc;
        req_d            = req_q;
        addr_d           = addr_q;
        wdata_d          = wdata_q;
        wstrb_d          = wstrb_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (bus.ex_exception_valid) begin
                        trap_valid_d = 1'b1;
                        trap_num_d   = bus.ex_exception_num;
                        trap_val_d   = bus.ex_exception_val;
                        trap_pc_d    = bus.ex_inst_pc;
                        flush_d      = 1'b1;
                        state_d      = FLUSH;
                    end else if (bus.ex_store_valid) begin
                        if (al_misaligned) begin
                            trap_valid_d = 1'b1;
                            trap_num_d   = EXC_STORE_MISALIGNED;
                            trap_val_d   = bus.ex_store_addr;
                            trap_pc_d    = bus.ex_inst_pc;
                            flush_d      = 1'b1;
                            state_d      = FLUSH;
                        end else begin
                            req_d       = 1'b1;
                            addr_d      = al_addr;
                            wdata_d     = al_wdata;
                            wstrb_d     = al_wstrb;
                            st_addr_d   = bus.ex_store_addr;
                            st_pc_d     = bus.ex_inst_pc;
                            commit_rd_d = bus.ex_rd;
                            cnt_d       = '0;
                            state_d     = STORE_WAIT;
                        end
                    end else begin
                        // Jumps and plain ops share the writeback path (link register).
                        wb_en_d  = (bus.ex_rd != 5'd0);
                        wb_rd_d  = bus.ex_rd;
                        wb_val_d = bus.ex_rd_val;
                        retire_d = 1'b1;
                        if (bus.ex_jump) begin
                            redirect_valid_d = 1'b1;
                            redirect_pc_d    = bus.ex_jump_pc;
                            flush_d          = FLUSH_ON_JUMP;
                            state_d          = FLUSH_ON_JUMP ? FLUSH : IDLE;
                        end
                    end
                end
            end
            STORE_WAIT: begin
                // Ack is checked first so it wins over a coincident timeout.
                if (bus.dmem_ack) begin
                    req_d       = 1'b0;
                    retire_d    = 1'b1;
                    commit_rd_d = 5'd0;
                    state_d     = IDLE;
                end else if ((DMEM_TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
                    req_d        = 1'b0;
                    trap_valid_d = 1'b1;
                    trap_num_d   = EXC_STORE_ACCESS_FAULT;
                    trap_val_d   = st_addr_q;
                    trap_pc_d    = st_pc_q;
                    flush_d      = 1'b1;
                    commit_rd_d  = 5'd0;
                    state_d      = FLUSH;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            FLUSH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            st_addr_q      <= 32'd0;
            st_pc_q        <= 32'd0;
            wb_en          <= 1'b0;
            wb_rd          <= 5'd0;
            wb_val         <= 32'd0;
            commit_rd      <= 5'd0;
            redirect_valid <= 1'b0;
            redirect_pc    <= 32'd0;
            flush_out      <= 1'b0;
            trap_valid     <= 1'b0;
            trap_num       <= 6'd0;
            trap_val       <= 32'd0;
            trap_pc        <= 32'd0;
            retire         <= 1'b0;
            req_q          <= 1'b0;
            addr_q         <= 32'd0;
            wdata_q        <= 32'd0;
            wstrb_q        <= 4'd0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            st_addr_q      <= st_addr_d;
            st_pc_q        <= st_pc_d;
            wb_en          <= wb_en_d;
            wb_rd          <= wb_rd_d;
            wb_val         <= wb_val_d;
            commit_rd      <= commit_rd_d;
            redirect_valid <= redirect_valid_d;
            redirect_pc    <= redirect_pc_d;
            flush_out      <= flush_d;
            trap_valid     <= trap_valid_d;
            trap_num       <= trap_num_d;
            trap_val       <= trap_val_d;
            trap_pc        <= trap_pc_d;
            retire         <= retire_d;
            req_q          <= req_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            wstrb_q        <= wstrb_d;
        end
    end

`ifdef STORE_COMMIT_INSTRET_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            instret <= 64'd0;
        end else if (retire_d) begin
            instret <= instret + 64'd1;
        end
    end
`endif

endmodule

// File: tb/tb_store_commit.sv
// tb/tb_store_commit.sv - self-checking bench for store_commit
module tb_store_commit;
    logic        clk;
    logic        reset;
    logic        wb_en, redirect_valid, flush_out, trap_valid, retire;
    logic [4:0]  wb_rd, commit_rd;
    logic [31:0] wb_val, redirect_pc, trap_val, trap_pc;
    logic [5:0]  trap_num;
`ifdef STORE_COMMIT_INSTRET_EN
    logic [63:0] instret;
`endif
    int n_pass;
    int n_total;

    store_commit_if bus ();

    store_commit #(.DMEM_TIMEOUT(8), .FLUSH_ON_JUMP(1'b1)) dut (
        .clk            (clk),
        .reset          (reset),
        .bus            (bus),
        .wb_en          (wb_en),
        .wb_rd          (wb_rd),
        .wb_val         (wb_val),
        .commit_rd      (commit_rd),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush_out      (flush_out),
        .trap_valid     (trap_valid),
        .trap_num       (trap_num),
        .trap_val       (trap_val),
        .trap_pc        (trap_pc),
        .retire         (retire)
`ifdef STORE_COMMIT_INSTRET_EN
        ,
        .instret        (instret)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] rd_val;
        logic [31:0] pc;
        logic [31:0] jump_pc;
        logic        jump;
        logic        exc;
        logic [5:0]  exc_num;
        logic [31:0] exc_val;
        logic        st;
        logic [31:0] st_addr;
        logic [31:0] st_val;
        logic [1:0]  st_size;
        logic        e_wb;
        logic        e_redir;
        logic        e_flush;
        logic        e_trap;
        logic [5:0]  e_trap_num;
        logic [31:0] e_trap_val;
        logic        e_req;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [3:0]  e_wstrb;
        logic        e_retire;
        logic        e_stall;
    } vec_t;

    vec_t v [15];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.ex_valid = 0; bus.ex_rd = 0; bus.ex_rd_val = 0; bus.ex_inst_pc = 0;
        bus.ex_jump_pc = 0; bus.ex_jump = 0; bus.ex_exception_num = 0;
        bus.ex_exception_val = 0; bus.ex_exception_valid = 0; bus.ex_store_addr = 0;
        bus.ex_store_val = 0; bus.ex_store_size = 0; bus.ex_store_valid = 0;
        bus.dmem_ack = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic drive(input vec_t x);
        bus.ex_valid = 1; bus.ex_rd = x.rd; bus.ex_rd_val = x.rd_val; bus.ex_inst_pc = x.pc;
        bus.ex_jump_pc = x.jump_pc; bus.ex_jump = x.jump; bus.ex_exception_valid = x.exc;
        bus.ex_exception_num = x.exc_num; bus.ex_exception_val = x.exc_val;
        bus.ex_store_valid = x.st; bus.ex_store_addr = x.st_addr;
        bus.ex_store_val = x.st_val; bus.ex_store_size = x.st_size;
    endtask

    task automatic set_store(input logic [4:0] rd, input logic [31:0] pc,
                             input logic [31:0] addr, input logic [31:0] val, input logic [1:0] size);
        clear_inputs();
        bus.ex_valid = 1; bus.ex_rd = rd; bus.ex_inst_pc = pc; bus.ex_store_valid = 1;
        bus.ex_store_addr = addr; bus.ex_store_val = val; bus.ex_store_size = size;
    endtask

    task automatic set_plain(input logic [4:0] rd, input logic [31:0] val, input logic [31:0] pc);
        clear_inputs();
        bus.ex_valid = 1; bus.ex_rd = rd; bus.ex_rd_val = val; bus.ex_inst_pc = pc;
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        reset = 1'b1;
        clear_inputs();

        //        rd    rd_val        pc      jump_pc  j  ex exn   exv    st st_addr    st_val        sz   wb rd fl tr tn   tv          rq addr      wdata         ws    rt sl
        v[0]  = '{5'd5, 32'h11,  32'h100, 32'h0,   0, 0, 6'd0, 32'h0,  0, 32'h0,    32'h0,        2'd0, 1, 0, 0, 0, 6'd0, 32'h0,    0, 32'h0,    32'h0,        4'h0, 1, 0};
        v[1]  = '{5'd0, 32'h22,  32'h104, 32'h0,   0, 0, 6'd0, 32'h0,  0, 32'h0,    32'h0,        2'd0, 0, 0, 0, 0, 6'd0, 32'h0,    0, 32'h0,    32'h0,        4'h0, 1, 0};
        v[2]  = '{5'd3, 32'h0,   32'h108, 32'h0,   0, 0, 6'd0, 32'h0,  1, 32'h1003, 32'hAB,       2'd0, 0, 0, 0, 0, 6'd0, 32'h0,    1, 32'h1000, 32'hABABABAB, 4'h8, 0, 1};
        v[3]  = '{5'd0, 32'h0,   32'h10C, 32'h0,   0, 0, 6'd0, 32'h0,  1, 32'h2002, 32'h1234CDEF, 2'd1, 0, 0, 0, 0, 6'd0, 32'h0,    1, 32'h2000, 32'hCDEFCDEF, 4'hC, 0, 1};
        v[4]  = '{5'd0, 32'h0,   32'h110, 32'h0,   0, 0, 6'd0, 32'h0,  1, 32'h3000, 32'hDEADBEEF, 2'd2, 0, 0, 0, 0, 6'd0, 32'h0,    1, 32'h3000, 32'hDEADBEEF, 4'hF, 0, 1};
        v[5]  = '{5'd0, 32'h0,   32'h114, 32'h0,   0, 0, 6'd0, 32'h0,  1, 32'h2001, 32'h55,       2'd1, 0, 0, 1, 1, 6'd6, 32'h2001, 0, 32'h0,    32'h0,        4'h0, 0, 1};
        v[6]  = '{5'd0, 32'h0,   32'h118, 32'h0,   0, 0, 6'd0, 32'h0,  1, 32'h3002, 32'h55,       2'd2, 0, 0, 1, 1, 6'd6, 32'h3002, 0, 32'h0,    32'h0,        4'h0, 0, 1};
        v[7]  = '{5'd0, 32'h0,   32'h11C, 32'h0,   0, 0, 6'd0, 32'h0,  1, 32'h4000, 32'h55,       2'd3, 0, 0, 1, 1, 6'd6, 32'h4000, 0, 32'h0,    32'h0,        4'h0, 0, 1};
        v[8]  = '{5'd7, 32'h9,   32'h200, 32'h0,   0, 1, 6'd2, 32'h55, 1, 32'h5000, 32'h1,        2'd2, 0, 0, 1, 1, 6'd2, 32'h55,   0, 32'h0,    32'h0,        4'h0, 0, 1};
        v[9]  = '{5'd1, 32'h104, 32'h100, 32'h400, 1, 0, 6'd0, 32'h0,  0, 32'h0,    32'h0,        2'd0, 1, 1, 1, 0, 6'd0, 32'h0,    0, 32'h0,    32'h0,        4'h0, 1, 1};
        v[10] = '{5'd0, 32'h104, 32'h120, 32'h800, 1, 0, 6'd0, 32'h0,  0, 32'h0,    32'h0,        2'd0, 0, 1, 1, 0, 6'd0, 32'h0,    0, 32'h0,    32'h0,        4'h0, 1, 1};
        v[11] = '{5'd2, 32'h1,   32'h124, 32'h900, 1, 0, 6'd0, 32'h0,  1, 32'h10,   32'h5,        2'd0, 0, 0, 0, 0, 6'd0, 32'h0,    1, 32'h10,   32'h05050505, 4'h1, 0, 1};
        v[12] = '{5'd0, 32'h0,   32'h128, 32'h0,   0, 0, 6'd0, 32'h0,  1, 32'h1001, 32'h7F,       2'd0, 0, 0, 0, 0, 6'd0, 32'h0,    1, 32'h1000, 32'h7F7F7F7F, 4'h2, 0, 1};
        v[13] = '{5'd0, 32'h0,   32'h12C, 32'h0,   0, 0, 6'd0, 32'h0,  1, 32'h0,    32'hBEEF,     2'd1, 0, 0, 0, 0, 6'd0, 32'h0,    1, 32'h0,    32'hBEEFBEEF, 4'h3, 0, 1};
        v[14] = '{5'd4, 32'h1,   32'h300, 32'hA00, 1, 1, 6'd3, 32'h77, 0, 32'h0,    32'h0,        2'd0, 0, 0, 1, 1, 6'd3, 32'h77,   0, 32'h0,    32'h0,        4'h0, 0, 1};

        tick();
        tick();
        chk("reset_wb_en", wb_en, 0);
        chk("reset_dmem_req", bus.dmem_req, 0);
        chk("reset_stall", bus.ex_stall, 0);
        chk("reset_trap_valid", trap_valid, 0);
        chk("reset_flush", flush_out, 0);
        chk("reset_retire", retire, 0);
        chk("reset_commit_rd", commit_rd, 0);
        chk("reset_redirect_valid", redirect_valid, 0);
        reset = 1'b0;

        for (int i = 0; i < 15; i++) begin
            do_reset();
            drive(v[i]);
            tick();
            clear_inputs();
            chk($sformatf("v%0d_wb_en", i), wb_en, v[i].e_wb);
            if (v[i].e_wb) begin
                chk($sformatf("v%0d_wb_rd", i), wb_rd, v[i].rd);
                chk($sformatf("v%0d_wb_val", i), wb_val, v[i].rd_val);
            end
            chk($sformatf("v%0d_redirect_valid", i), redirect_valid, v[i].e_redir);
            if (v[i].e_redir) chk($sformatf("v%0d_redirect_pc", i), redirect_pc, v[i].jump_pc);
            chk($sformatf("v%0d_flush", i), flush_out, v[i].e_flush);
            chk($sformatf("v%0d_trap_valid", i), trap_valid, v[i].e_trap);
            if (v[i].e_trap) begin
                chk($sformatf("v%0d_trap_num", i), trap_num, v[i].e_trap_num);
                chk($sformatf("v%0d_trap_val", i), trap_val, v[i].e_trap_val);
                chk($sformatf("v%0d_trap_pc", i), trap_pc, v[i].pc);
            end
            chk($sformatf("v%0d_dmem_req", i), bus.dmem_req, v[i].e_req);
            if (v[i].e_req) begin
                chk($sformatf("v%0d_dmem_addr", i), bus.dmem_addr, v[i].e_addr);
                chk($sformatf("v%0d_dmem_wdata", i), bus.dmem_wdata, v[i].e_wdata);
                chk($sformatf("v%0d_dmem_wstrb", i), bus.dmem_wstrb, v[i].e_wstrb);
                chk($sformatf("v%0d_commit_rd", i), commit_rd, v[i].rd);
            end
            chk($sformatf("v%0d_retire", i), retire, v[i].e_retire);
            chk($sformatf("v%0d_stall", i), bus.ex_stall, v[i].e_stall);
        end

        // Back-to-back writebacks.
        do_reset();
        set_plain(5'd5, 32'h11, 32'h100);
        tick();
        chk("b2b_wb_en_1", wb_en, 1);
        chk("b2b_wb_rd_1", wb_rd, 5);
        chk("b2b_wb_val_1", wb_val, 32'h11);
        chk("b2b_stall_1", bus.ex_stall, 0);
        set_plain(5'd0, 32'h22, 32'h104);
        tick();
        chk("b2b_wb_en_2", wb_en, 0);
        chk("b2b_retire_2", retire, 1);
        chk("b2b_stall_2", bus.ex_stall, 0);
        clear_inputs();
        tick();
        chk("b2b_retire_pulse", retire, 0);

        // Byte store acked in its third wait cycle.
        do_reset();
        set_store(5'd9, 32'h200, 32'h1003, 32'hAB, 2'd0);
        tick();
        clear_inputs();
        chk("st_req", bus.dmem_req, 1);
        chk("st_commit_rd", commit_rd, 9);
        tick();
        tick();
        chk("st_req_held", bus.dmem_req, 1);
        chk("st_wdata_held", bus.dmem_wdata, 32'hABABABAB);
        chk("st_wstrb_held", bus.dmem_wstrb, 4'b1000);
        chk("st_no_retire_yet", retire, 0);
        bus.dmem_ack = 1;
        tick();
        bus.dmem_ack = 0;
        chk("st_ack_req_drop", bus.dmem_req, 0);
        chk("st_ack_retire", retire, 1);
        chk("st_ack_stall", bus.ex_stall, 0);
        chk("st_ack_commit_rd", commit_rd, 0);
        chk("st_ack_no_wb", wb_en, 0);
        tick();
        chk("st_retire_pulse", retire, 0);

        // Store timeout after 8 wait cycles.
        do_reset();
        set_store(5'd0, 32'h300, 32'h5000, 32'h1, 2'd2);
        tick();
        clear_inputs();
        for (int k = 0; k < 7; k++) tick();
        chk("to_req_before", bus.dmem_req, 1);
        chk("to_no_trap_before", trap_valid, 0);
        tick();
        chk("to_trap_valid", trap_valid, 1);
        chk("to_trap_num", trap_num, 7);
        chk("to_trap_val", trap_val, 32'h5000);
        chk("to_trap_pc", trap_pc, 32'h300);
        chk("to_flush", flush_out, 1);
        chk("to_req_drop", bus.dmem_req, 0);
        chk("to_stall_flush", bus.ex_stall, 1);
        chk("to_no_retire", retire, 0);
        tick();
        chk("to_stall_after", bus.ex_stall, 0);
        chk("to_trap_pulse", trap_valid, 0);

        // Ack coinciding with the timeout cycle wins.
        do_reset();
        set_store(5'd0, 32'h304, 32'h5004, 32'h1, 2'd2);
        tick();
        clear_inputs();
        for (int k = 0; k < 7; k++) tick();
        bus.dmem_ack = 1;
        tick();
        bus.dmem_ack = 0;
        chk("tie_retire", retire, 1);
        chk("tie_no_trap", trap_valid, 0);
        chk("tie_req_drop", bus.dmem_req, 0);

        // Jump: one FLUSH cycle ignores a held bundle, then it is accepted.
        do_reset();
        clear_inputs();
        bus.ex_valid = 1; bus.ex_rd = 5'd1; bus.ex_rd_val = 32'h104;
        bus.ex_inst_pc = 32'h100; bus.ex_jump = 1; bus.ex_jump_pc = 32'h400;
        tick();
        chk("jmp_redirect_pc", redirect_pc, 32'h400);
        chk("jmp_wb_rd", wb_rd, 1);
        chk("jmp_stall", bus.ex_stall, 1);
        set_plain(5'd4, 32'h44, 32'h104);
        tick();
        chk("jmp_flush_ignored_wb", wb_en, 0);
        chk("jmp_flush_pulse", flush_out, 0);
        chk("jmp_stall_release", bus.ex_stall, 0);
        tick();
        clear_inputs();
        chk("jmp_after_wb_en", wb_en, 1);
        chk("jmp_after_wb_val", wb_val, 32'h44);

        // Reset during STORE_WAIT abandons the store; a late ack is ignored.
        do_reset();
        set_store(5'd6, 32'h600, 32'h6000, 32'h12, 2'd2);
        tick();
        clear_inputs();
        chk("rst_mid_req", bus.dmem_req, 1);
        reset = 1'b1;
        tick();
        chk("rst_mid_req_drop", bus.dmem_req, 0);
        chk("rst_mid_stall", bus.ex_stall, 0);
        chk("rst_mid_commit_rd", commit_rd, 0);
        chk("rst_mid_trap", trap_valid, 0);
        reset = 1'b0;
        bus.dmem_ack = 1;
        tick();
        bus.dmem_ack = 0;
        chk("late_ack_no_retire", retire, 0);
        chk("late_ack_no_req", bus.dmem_req, 0);
        chk("late_ack_stall", bus.ex_stall, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
